// File: rtl/anton_neopixel_stream_tx_pkg.sv
//------------------------------------------------------------------------------
// Module  : anton_neopixel_stream_tx_pkg
// Brief   : Shared constants, state encoding and helpers for the NeoPixel
//           stream transmitter (optional loop build: ANTON_NEOPIXEL_LOOP_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package anton_neopixel_stream_tx_pkg;

   localparam int BUFFER_END_DEFAULT   = 256;
   localparam int BIT_CYCLES_DEFAULT   = 25;
   localparam int T0H_CYCLES_DEFAULT   = 8;
   localparam int T1H_CYCLES_DEFAULT   = 16;
   localparam int LATCH_CYCLES_DEFAULT = 1000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      BIT   = 3'd2,
      LATCH = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Address/length width: must be able to hold BUFFER_END itself.
   function automatic int buffer_bits(input int buffer_end);
      return $clog2(buffer_end + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/anton_neopixel_stream_tx_if.sv
//------------------------------------------------------------------------------
// Module  : anton_neopixel_stream_tx_if
// Brief   : Control handshake and buffer-RAM read port of the NeoPixel
//           stream transmitter; master = controller/RAM side, slave = block.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface anton_neopixel_stream_tx_if
   import anton_neopixel_stream_tx_pkg::*;
#(
   parameter int BUFFER_END = BUFFER_END_DEFAULT
);
   localparam int BUFFER_BITS = buffer_bits(BUFFER_END);

   logic                   start;
   logic [BUFFER_BITS-1:0] len;
   logic [BUFFER_BITS-1:0] raddr;
   logic [7:0]             rdata;
   logic                   busy;
   logic                   done;

   modport master (
      output start,
      output len,
      output rdata,
      input  raddr,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  len,
      input  rdata,
      output raddr,
      output busy,
      output done
   );

endinterface

`default_nettype wire

// File: rtl/anton_neopixel_bit_encoder.sv
//------------------------------------------------------------------------------
// Module  : anton_neopixel_bit_encoder
// Brief   : Times one WS2812 bit period and produces its high/low waveform.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module anton_neopixel_bit_encoder #(
   parameter int BIT_CYCLES = 25,
   parameter int T0H_CYCLES = 8,
   parameter int T1H_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic bit_val,
   input  logic bit_start,
   output logic neo_out,
   output logic bit_last
);
   localparam int                 c_cnt_w    = $clog2(BIT_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIT_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_t0h      = c_cnt_w'(T0H_CYCLES);
   localparam logic [c_cnt_w-1:0] c_t1h      = c_cnt_w'(T1H_CYCLES);

   generate
      if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES))) begin : g_timing_check
         $error("anton_neopixel_bit_encoder: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
      end
   endgenerate

   logic               r_active;
   logic [c_cnt_w-1:0] r_cnt;

   assign bit_last = r_active && (r_cnt == c_cnt_last);
   assign neo_out  = r_active && (r_cnt < (bit_val ? c_t1h : c_t0h));

   // A bit_start on the last cycle of a period chains the next bit with no gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
      end else if (bit_start) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
      end else if (bit_last) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
      end else if (r_active) begin
         r_cnt    <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/anton_neopixel_stream_tx.sv
//------------------------------------------------------------------------------
// Module  : anton_neopixel_stream_tx
// Brief   : Reads bytes 0..len-1 from the pixel buffer and serializes them as a
//           NeoPixel frame followed by a latch gap. Macro ANTON_NEOPIXEL_LOOP_EN
//           adds a 'loop' input for continuous refresh.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module anton_neopixel_stream_tx
   import anton_neopixel_stream_tx_pkg::*;
#(
   parameter int BUFFER_END   = BUFFER_END_DEFAULT,
   parameter int BIT_CYCLES   = BIT_CYCLES_DEFAULT,
   parameter int T0H_CYCLES   = T0H_CYCLES_DEFAULT,
   parameter int T1H_CYCLES   = T1H_CYCLES_DEFAULT,
   parameter int LATCH_CYCLES = LATCH_CYCLES_DEFAULT
) (
   input  logic                     clk,
   input  logic                     reset,
   anton_neopixel_stream_tx_if.slave bus,
`ifdef ANTON_NEOPIXEL_LOOP_EN
   input  logic                     loop,
`endif
   output logic                     neo_out
);
   localparam int BUFFER_BITS = buffer_bits(BUFFER_END);
   localparam int c_latch_w   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

   localparam logic [BUFFER_BITS-1:0] c_len_max    = BUFFER_BITS'(BUFFER_END);
   localparam logic [c_latch_w-1:0]   c_latch_last = c_latch_w'(LATCH_CYCLES - 1);

   state_t                 r_state;
   logic                   r_fetch_second;
   logic [BUFFER_BITS-1:0] r_len_q;
   logic [BUFFER_BITS-1:0] r_raddr;
   logic [7:0]             r_shift;
   logic [2:0]             r_bit_idx;
   logic [c_latch_w-1:0]   r_latch_cnt;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_loop_q;

   logic                   w_loop;
   logic                   w_bit_start;
   logic                   w_bit_last;
   logic                   w_byte_end;
   logic                   w_frame_end;
   logic [BUFFER_BITS-1:0] w_len_clamped;

`ifdef ANTON_NEOPIXEL_LOOP_EN
   assign w_loop = loop;
`else
   assign w_loop = 1'b0;
`endif

   assign w_len_clamped = (bus.len > c_len_max) ? c_len_max : bus.len;

   // raddr always points at the byte after the one being shifted out, so the
   // current byte is the last one exactly when raddr has reached len_q.
   assign w_byte_end  = (r_state == BIT) && w_bit_last && (r_bit_idx == 3'd7);
   assign w_frame_end = w_byte_end && (r_raddr == r_len_q);
   assign w_bit_start = ((r_state == FETCH) && r_fetch_second) ||
                        ((r_state == BIT) && w_bit_last && !w_frame_end);

   assign bus.raddr = r_raddr;
   assign bus.busy  = r_busy;
   assign bus.done  = r_done;

   anton_neopixel_bit_encoder #(
      .BIT_CYCLES (BIT_CYCLES),
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES)
   ) u_bit_encoder (
      .clk       (clk),
      .reset     (reset),
      .bit_val   (r_shift[7]),
      .bit_start (w_bit_start),
      .neo_out   (neo_out),
      .bit_last  (w_bit_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= IDLE;
         r_fetch_second <= 1'b0;
         r_len_q        <= '0;
         r_raddr        <= '0;
         r_shift        <= '0;
         r_bit_idx      <= '0;
         r_latch_cnt    <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_loop_q       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_len_q        <= w_len_clamped;
                  r_busy         <= 1'b1;
                  r_loop_q       <= 1'b0;
                  r_fetch_second <= 1'b0;
                  r_state        <= (w_len_clamped == '0) ? DONE : FETCH;
               end
            end
            FETCH: begin
               if (!r_fetch_second) begin
                  r_fetch_second <= 1'b1;
               end else begin
                  r_shift   <= bus.rdata;
                  r_raddr   <= r_raddr + 1'b1;
                  r_bit_idx <= '0;
                  r_state   <= BIT;
               end
            end
            BIT: begin
               if (w_bit_last) begin
                  if (w_frame_end) begin
                     r_latch_cnt <= '0;
                     r_state     <= LATCH;
                  end else if (r_bit_idx == 3'd7) begin
                     r_shift   <= bus.rdata;
                     r_raddr   <= r_raddr + 1'b1;
                     r_bit_idx <= '0;
                  end else begin
                     r_shift   <= {r_shift[6:0], 1'b0};
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            LATCH: begin
               if (r_latch_cnt == c_latch_last) begin
                  r_loop_q <= w_loop;
                  r_state  <= DONE;
               end else begin
                  r_latch_cnt <= r_latch_cnt + 1'b1;
               end
            end
            DONE: begin
               r_done      <= 1'b1;
               r_raddr     <= '0;
               r_latch_cnt <= '0;
               if (r_loop_q) begin
                  r_fetch_second <= 1'b0;
                  r_state        <= FETCH;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_anton_neopixel_stream_tx.sv
//------------------------------------------------------------------------------
// Module  : tb_anton_neopixel_stream_tx
// Brief   : Self-checking bench for anton_neopixel_stream_tx against a
//           cycle-indexed waveform model (loop test under ANTON_NEOPIXEL_LOOP_EN).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_anton_neopixel_stream_tx;
   import anton_neopixel_stream_tx_pkg::*;

   localparam int BUFFER_END   = 8;
   localparam int BUFFER_BITS  = buffer_bits(BUFFER_END);
   localparam int BIT_CYCLES   = 25;
   localparam int T0H_CYCLES   = 8;
   localparam int T1H_CYCLES   = 16;
   localparam int LATCH_CYCLES = 1000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic neo_out;
`ifdef ANTON_NEOPIXEL_LOOP_EN
   logic loop  = 1'b0;
`endif

   logic [7:0] ram [0:15];
   int n_cmp = 0;
   int n_bad = 0;

   anton_neopixel_stream_tx_if #(.BUFFER_END(BUFFER_END)) bus ();

   anton_neopixel_stream_tx #(
      .BUFFER_END   (BUFFER_END),
      .BIT_CYCLES   (BIT_CYCLES),
      .T0H_CYCLES   (T0H_CYCLES),
      .T1H_CYCLES   (T1H_CYCLES),
      .LATCH_CYCLES (LATCH_CYCLES)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
`ifdef ANTON_NEOPIXEL_LOOP_EN
      .loop    (loop),
`endif
      .neo_out (neo_out)
   );

   always #5 clk = ~clk;

   // Buffer RAM with a registered read address.
   always @(posedge clk) bus.rdata <= ram[bus.raddr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected neo_out and raddr for every cycle after the start edge, up to and
   // including the cycle where done is high.
   function automatic void model_frame(input byte unsigned data[$], output bit w[$],
                                       output int ra[$], output int done_cyc);
      int n, k, byte_i, bitpos, phase;
      byte unsigned cur;
      n = data.size();
      w = {};
      ra = {};
      done_cyc = (n == 0) ? 1 : 2 + 8 * n * BIT_CYCLES + LATCH_CYCLES + 1;
      for (int c = 0; c < done_cyc; c++) begin
         if (n == 0 || c < 2) begin
            w.push_back(1'b0);
            ra.push_back(0);
         end else if (c < 2 + 8 * n * BIT_CYCLES) begin
            k      = c - 2;
            byte_i = k / (8 * BIT_CYCLES);
            bitpos = (k / BIT_CYCLES) % 8;
            phase  = k % BIT_CYCLES;
            cur    = data[byte_i];
            w.push_back(phase < (cur[7 - bitpos] ? T1H_CYCLES : T0H_CYCLES));
            ra.push_back(byte_i + 1);
         end else begin
            w.push_back(1'b0);
            ra.push_back(n);
         end
      end
      w.push_back(1'b0);
      ra.push_back(0);
   endfunction

   function automatic void high_runs(input bit w[$], output int runs[$]);
      int n;
      n = 0;
      runs = {};
      foreach (w[i]) begin
         if (w[i]) n++;
         else if (n > 0) begin
            runs.push_back(n);
            n = 0;
         end
      end
      if (n > 0) runs.push_back(n);
   endfunction

   // Starts a frame from a negedge and checks it cycle by cycle; a stray start
   // pulse is injected at cycle stray_at (negative = none).
   task automatic run_frame(input string tag, input int req_len, input int stray_at);
      byte unsigned data[$];
      bit exp_w[$], obs_w[$];
      int exp_ra[$], exp_runs[$], obs_runs[$];
      int done_cyc, eff, first_done, wave_bad, ra_bad, busy_bad;
      logic done_after;
      eff = (req_len > BUFFER_END) ? BUFFER_END : req_len;
      for (int i = 0; i < eff; i++) data.push_back(ram[i]);
      model_frame(data, exp_w, exp_ra, done_cyc);
      first_done = -1;
      wave_bad   = 0;
      ra_bad     = 0;
      busy_bad   = 0;
      done_after = 1'b0;
      bus.len    = BUFFER_BITS'(req_len);
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start  = 1'b0;
      for (int c = 0; c <= done_cyc + 1; c++) begin
         obs_w.push_back(neo_out === 1'b1);
         if (c <= done_cyc) begin
            if (neo_out !== exp_w[c]) wave_bad++;
            if (bus.raddr !== BUFFER_BITS'(exp_ra[c])) ra_bad++;
            if (bus.busy !== 1'(c < done_cyc)) busy_bad++;
         end else begin
            done_after = bus.done;
         end
         if (bus.done === 1'b1 && first_done < 0) first_done = c;
         bus.start = (c == stray_at);
         if (c == stray_at) bus.len = BUFFER_BITS'($urandom_range(1, BUFFER_END));
         @(negedge clk);
      end
      bus.start = 1'b0;
      check({tag, " done_cycle"}, first_done, done_cyc);
      check({tag, " done_width"}, 32'(done_after), 0);
      check({tag, " wave_errs"}, wave_bad, 0);
      check({tag, " raddr_errs"}, ra_bad, 0);
      check({tag, " busy_errs"}, busy_bad, 0);
      high_runs(exp_w, exp_runs);
      high_runs(obs_w, obs_runs);
      check({tag, " high_runs"}, obs_runs.size(), exp_runs.size());
      for (int i = 0; i < exp_runs.size() && i < obs_runs.size(); i++)
         check($sformatf("%s run%0d", tag, i), obs_runs[i], exp_runs[i]);
   endtask

   task automatic abort_test();
      int dones;
      for (int i = 0; i < 3; i++) ram[i] = 8'hFF;
      bus.len   = BUFFER_BITS'(3);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (203) @(negedge clk);
      check("abort pre_neo", 32'(neo_out), 1);
      reset = 1'b1;
      @(negedge clk);
      check("abort neo", 32'(neo_out), 0);
      check("abort busy", 32'(bus.busy), 0);
      check("abort done", 32'(bus.done), 0);
      check("abort raddr", 32'(bus.raddr), 0);
      reset = 1'b0;
      dones = 0;
      repeat (1500) begin
         @(negedge clk);
         if (bus.done !== 1'b0) dones++;
      end
      check("abort no_done", dones, 0);
   endtask

`ifdef ANTON_NEOPIXEL_LOOP_EN
   task automatic run_loop();
      int period, busy_low;
      int dones[$];
      logic busy_end;
      period   = 2 + 8 * 2 * BIT_CYCLES + LATCH_CYCLES + 1;
      busy_low = 0;
      busy_end = 1'b1;
      ram[0] = 8'($urandom);
      ram[1] = 8'($urandom);
      bus.len   = BUFFER_BITS'(2);
      loop      = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 4 * period; c++) begin
         if (bus.done === 1'b1) dones.push_back(c);
         if (c < 3 * period && bus.busy !== 1'b1) busy_low++;
         if (c == 3 * period) busy_end = bus.busy;
         if (c == 2 * period + 1) loop = 1'b0;
         @(negedge clk);
      end
      check("loop done_count", dones.size(), 3);
      for (int i = 0; i < dones.size() && i < 3; i++)
         check($sformatf("loop done%0d", i), dones[i], (i + 1) * period);
      check("loop busy_low", busy_low, 0);
      check("loop busy_end", 32'(busy_end), 0);
   endtask
`endif

   initial begin
      int bad, dones;
      bus.start = 1'b0;
      bus.len   = '0;
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset neo", 32'(neo_out), 0);
      check("reset busy", 32'(bus.busy), 0);
      check("reset done", 32'(bus.done), 0);
      check("reset raddr", 32'(bus.raddr), 0);
      reset = 1'b0;

      bad   = 0;
      dones = 0;
      repeat (100) begin
         @(negedge clk);
         if (neo_out !== 1'b0 || bus.busy !== 1'b0 || bus.raddr !== '0) bad++;
         if (bus.done !== 1'b0) dones++;
      end
      check("idle outputs", bad, 0);
      check("idle done", dones, 0);

      ram[0] = 8'hA5;
      run_frame("a5", 1, -1);
      ram[0] = 8'hFF; ram[1] = 8'h00; ram[2] = 8'h81;
      run_frame("three", 3, -1);
      run_frame("len0", 0, -1);

      for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
      run_frame("stray", 2, 150 + int'($urandom_range(0, 200)));

      abort_test();
      ram[0] = 8'h3C; ram[1] = 8'hC3; ram[2] = 8'h5A;
      run_frame("restart", 3, -1);

      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
         run_frame($sformatf("rand%0d", f), int'($urandom_range(1, 4)), -1);
      end

      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      run_frame("clamp15", 15, -1);

`ifdef ANTON_NEOPIXEL_LOOP_EN
      run_loop();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
